ps2_keycode_decoder: RTL and testbench
======================================

// Module: ps2_keycode_decoder
// PURPOSE
//  Decodes PS/2 scan-code set 2 bytes into ASCII characters for the keyboard FPGA.
//  Successor to the single-byte decoder: fully synchronous, tracks E0/F0/E1 prefixes and
//  left/right modifiers, and buffers characters in a FIFO with a valid/ready output.
//  Sits between the PS/2 receiver (byte strobe) and the host-side character interface.
// PARAMETERS
//  FIFO_DEPTH   8  output character FIFO entries; power of two, >= 2
//  CTRL_CODES   1  1: Ctrl+letter emits control code (letter & 8'h1F); 0: emits the plain letter
//  MAP_EXTENDED 1  1: E0-prefixed navigation keys emit 8'h80-8'h8F codes; 0: E0 keys emit nothing
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  scancode        in   8  received PS/2 byte
//  scancode_valid  in   1  one-cycle strobe, scancode valid this cycle
//  ascii           out  8  FIFO head character
//  ascii_valid     out  1  FIFO non-empty
//  ascii_ready     in   1  consumer pops head when ascii_valid && ascii_ready
//  reset_required  out  1  one-cycle pulse: BAT-complete byte 8'hAA received in IDLE
//  shift           out  1  left_shift | right_shift held
//  ctrl            out  1  left or right ctrl held
//  alt             out  1  left or right alt held
//  caps_lock       out  1  caps-lock toggle state (drives keyboard LED logic)
//  overflow        out  1  sticky: a character was dropped on a full FIFO
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, all modifier/held flags 0. Strobes during reset ignored.
//  Only cycles with scancode_valid=1 advance the FSM. FSM states:
//   IDLE:      F0->BREAK; E0->EXT; E1->PAUSE (skip=7); AA->pulse reset_required; else make(code,ext=0)
//   BREAK:     any->break(code,ext=0), ->IDLE
//   EXT:       F0->EXT_BREAK; else make(code,ext=1), ->IDLE
//   EXT_BREAK: any->break(code,ext=1), ->IDLE
//   PAUSE:     decrement skip each byte; ->IDLE when skip reaches 0; emits nothing
//  Modifiers (set on make, clear on break): 12=lshift, 59=rshift (ext ignored: fake shifts);
//   14=lctrl, E0 14=rctrl; 11=lalt, E0 11=ralt. Modifier bytes never emit characters.
//  Caps lock: make of 58 (ext=0) toggles caps_lock only if caps_held=0, then sets caps_held;
//   break clears caps_held (typematic repeat does not re-toggle).
//  Character make (ext=0): ROM lookup {shift_plane,code}; zero entry -> no emit.
//   Letters a-z: uppercase iff shift ^ caps_lock. Other keys: shifted plane iff shift.
//   If ctrl && CTRL_CODES && letter: emit uppercase & 8'h1F. Alt does not alter the code.
//   Typematic repeats (repeated makes) emit each time. Breaks never emit.
//  Extended make with MAP_EXTENDED=1: ext ROM lookup (e.g. E0 75 up->8'h80, E0 72 down->8'h81,
//   E0 6B left->8'h82, E0 74 right->8'h83); zero entry -> no emit.
//  Latency: strobe in cycle N -> decode register N+1 -> FIFO write; ascii_valid high in N+2 when
//   FIFO was empty. Modifier/caps outputs update in N+1.
//  FIFO: first-word-fall-through. Push when full and no pop in the same cycle: character dropped,
//   overflow set until reset. Push and pop in the same cycle when full: both accepted, count unchanged.
//   Pop on empty is ignored. ascii holds its value while ascii_valid && !ascii_ready.
//  Pointer widths: $clog2(FIFO_DEPTH); count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo depth.
//  Reset mid-sequence (e.g. after F0) discards the prefix; the next byte is treated in IDLE.
// STRUCTURE
//  Package ps2_keys_pkg: FSM state enum, prefix constants (F0,E0,E1,AA), modifier/caps codes,
//   extended key code constants (8'h80..), FIFO_DEPTH default.
//  Sub-module ps2_char_fifo (parametrised FWFT FIFO with overflow flag); ROM tables inline as
//   case-based functions in the decoder.
// TESTING
//  1C -> one char 8'h61 'a'; F0 1C -> nothing; ascii_valid asserted exactly 2 cycles after 1C strobe.
//  12,1C,F0 1C,F0 12,1C -> 'A'(8'h41) then 'a'(8'h61); shift=0 at end.
//  58,58,F0 58,1C -> caps_lock=1 (single toggle), emits 'A'; 12,1C with caps on -> 'a'.
//  14,21 with CTRL_CODES=1 -> 8'h03; E0 14 then F0 14 -> ctrl stays 1 until E0 F0 14.
//  E1 14 77 E1 F0 14 F0 77 then 1C -> only 'a'; E0 75 -> 8'h80; AA in IDLE -> reset_required 1-cycle pulse.
//  ascii_ready=0, 9 makes with FIFO_DEPTH=8 -> 8 chars kept in order, overflow=1; drain -> 8 pops, valid=0.

Source files
------------

// File: rtl/ps2_keys_pkg.sv
// Shared definitions for the PS/2 set-2 keycode decoder: decoder states, prefix and
// modifier scan codes, extended-key character codes and ROM entry helpers.
package ps2_keys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK,
        ST_PAUSE
    } dec_state_t;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;
    localparam logic [7:0] KEY_CAPS   = 8'h58;

    // Pause/Break sends E1 followed by seven more bytes that carry no key information
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [7:0] ASC_UP     = 8'h80;
    localparam logic [7:0] ASC_DOWN   = 8'h81;
    localparam logic [7:0] ASC_LEFT   = 8'h82;
    localparam logic [7:0] ASC_RIGHT  = 8'h83;
    localparam logic [7:0] ASC_HOME   = 8'h84;
    localparam logic [7:0] ASC_END    = 8'h85;
    localparam logic [7:0] ASC_PGUP   = 8'h86;
    localparam logic [7:0] ASC_PGDN   = 8'h87;
    localparam logic [7:0] ASC_INSERT = 8'h88;
    localparam logic [7:0] ASC_DELETE = 8'h89;
    localparam logic [7:0] ASC_KP_DIV = 8'h8A;
    localparam logic [7:0] ASC_KP_ENT = 8'h8B;

    localparam int FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic       letter;
        logic [7:0] hi;
        logic [7:0] lo;
    } char_entry_t;

    function automatic char_entry_t mk_letter(input logic [7:0] lower);
        char_entry_t e;
        e.letter = 1'b1;
        e.lo     = lower;
        e.hi     = lower - 8'h20;
        return e;
    endfunction

    function automatic char_entry_t mk_sym(input logic [7:0] lo, input logic [7:0] hi);
        char_entry_t e;
        e.letter = 1'b0;
        e.lo     = lo;
        e.hi     = hi;
        return e;
    endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// First-word-fall-through character FIFO with a sticky overflow flag; a push into a
// full FIFO is only accepted when a pop frees the head in the same cycle.
module ps2_char_fifo
    import ps2_keys_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;

    logic full;
    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign valid    = (count_reg != '0);
    // Head is forced to zero while empty so the output is defined straight out of reset
    assign data     = valid ? mem[rd_ptr_reg] : '0;
    assign overflow = overflow_reg;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 scan-code set 2 to ASCII decoder: prefix FSM, modifier tracking, character
// ROMs and an output FIFO with valid/ready handshake.
module ps2_keycode_decoder
    import ps2_keys_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter bit CTRL_CODES   = 1'b1,
    parameter bit MAP_EXTENDED = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       reset_required,
    output logic       shift,
    output logic       ctrl,
    output logic       alt,
    output logic       caps_lock,
    output logic       overflow
);

    function automatic char_entry_t char_rom(input logic [7:0] code);
        char_entry_t e;
        e = mk_sym(8'h00, 8'h00);
        case (code)
            8'h1C: e = mk_letter(8'h61);
            8'h32: e = mk_letter(8'h62);
            8'h21: e = mk_letter(8'h63);
            8'h23: e = mk_letter(8'h64);
            8'h24: e = mk_letter(8'h65);
            8'h2B: e = mk_letter(8'h66);
            8'h34: e = mk_letter(8'h67);
            8'h33: e = mk_letter(8'h68);
            8'h43: e = mk_letter(8'h69);
            8'h3B: e = mk_letter(8'h6A);
            8'h42: e = mk_letter(8'h6B);
            8'h4B: e = mk_letter(8'h6C);
            8'h3A: e = mk_letter(8'h6D);
            8'h31: e = mk_letter(8'h6E);
            8'h44: e = mk_letter(8'h6F);
            8'h4D: e = mk_letter(8'h70);
            8'h15: e = mk_letter(8'h71);
            8'h2D: e = mk_letter(8'h72);
            8'h1B: e = mk_letter(8'h73);
            8'h2C: e = mk_letter(8'h74);
            8'h3C: e = mk_letter(8'h75);
            8'h2A: e = mk_letter(8'h76);
            8'h1D: e = mk_letter(8'h77);
            8'h22: e = mk_letter(8'h78);
            8'h35: e = mk_letter(8'h79);
            8'h1A: e = mk_letter(8'h7A);
            8'h45: e = mk_sym(8'h30, 8'h29);
            8'h16: e = mk_sym(8'h31, 8'h21);
            8'h1E: e = mk_sym(8'h32, 8'h40);
            8'h26: e = mk_sym(8'h33, 8'h23);
            8'h25: e = mk_sym(8'h34, 8'h24);
            8'h2E: e = mk_sym(8'h35, 8'h25);
            8'h36: e = mk_sym(8'h36, 8'h5E);
            8'h3D: e = mk_sym(8'h37, 8'h26);
            8'h3E: e = mk_sym(8'h38, 8'h2A);
            8'h46: e = mk_sym(8'h39, 8'h28);
            8'h29: e = mk_sym(8'h20, 8'h20);
            8'h5A: e = mk_sym(8'h0D, 8'h0D);
            8'h66: e = mk_sym(8'h08, 8'h08);
            8'h0D: e = mk_sym(8'h09, 8'h09);
            8'h76: e = mk_sym(8'h1B, 8'h1B);
            8'h0E: e = mk_sym(8'h60, 8'h7E);
            8'h4E: e = mk_sym(8'h2D, 8'h5F);
            8'h55: e = mk_sym(8'h3D, 8'h2B);
            8'h54: e = mk_sym(8'h5B, 8'h7B);
            8'h5B: e = mk_sym(8'h5D, 8'h7D);
            8'h5D: e = mk_sym(8'h5C, 8'h7C);
            8'h4C: e = mk_sym(8'h3B, 8'h3A);
            8'h52: e = mk_sym(8'h27, 8'h22);
            8'h41: e = mk_sym(8'h2C, 8'h3C);
            8'h49: e = mk_sym(8'h2E, 8'h3E);
            8'h4A: e = mk_sym(8'h2F, 8'h3F);
            default: e = mk_sym(8'h00, 8'h00);
        endcase
        return e;
    endfunction

    function automatic logic [7:0] ext_rom(input logic [7:0] code);
        logic [7:0] c;
        case (code)
            8'h75:   c = ASC_UP;
            8'h72:   c = ASC_DOWN;
            8'h6B:   c = ASC_LEFT;
            8'h74:   c = ASC_RIGHT;
            8'h6C:   c = ASC_HOME;
            8'h69:   c = ASC_END;
            8'h7D:   c = ASC_PGUP;
            8'h7A:   c = ASC_PGDN;
            8'h70:   c = ASC_INSERT;
            8'h71:   c = ASC_DELETE;
            8'h4A:   c = ASC_KP_DIV;
            8'h5A:   c = ASC_KP_ENT;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    dec_state_t state_reg;
    logic [2:0] skip_reg;
    logic       lshift_reg, rshift_reg;
    logic       lctrl_reg, rctrl_reg;
    logic       lalt_reg, ralt_reg;
    logic       caps_reg, caps_held_reg;
    logic [7:0] char_reg;
    logic       char_valid_reg;
    logic       reset_req_reg;

    logic        key_event, key_make, key_ext;
    logic        shift_held, ctrl_held;
    char_entry_t entry;
    logic [7:0]  char_next;
    logic        emit_next;

    assign shift_held = lshift_reg | rshift_reg;
    assign ctrl_held  = lctrl_reg | rctrl_reg;

    // Classify the incoming byte as a make/break of a (possibly extended) key
    always_comb begin
        key_event = 1'b0;
        key_make  = 1'b0;
        key_ext   = 1'b0;
        if (scancode_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (scancode != CODE_BREAK && scancode != CODE_EXT &&
                        scancode != CODE_PAUSE && scancode != CODE_BAT_OK) begin
                        key_event = 1'b1;
                        key_make  = 1'b1;
                    end
                end
                ST_BREAK: key_event = 1'b1;
                ST_EXT: begin
                    if (scancode != CODE_BREAK) begin
                        key_event = 1'b1;
                        key_make  = 1'b1;
                        key_ext   = 1'b1;
                    end
                end
                ST_EXT_BREAK: begin
                    key_event = 1'b1;
                    key_ext   = 1'b1;
                end
                default: key_event = 1'b0;
            endcase
        end
    end

    always_comb begin
        entry     = char_rom(scancode);
        char_next = 8'h00;
        if (key_ext) begin
            char_next = MAP_EXTENDED ? ext_rom(scancode) : 8'h00;
        end else if (entry.letter) begin
            if (ctrl_held && CTRL_CODES) begin
                char_next = entry.hi & 8'h1F;
            end else begin
                char_next = (shift_held ^ caps_reg) ? entry.hi : entry.lo;
            end
        end else begin
            char_next = shift_held ? entry.hi : entry.lo;
        end
    end

    // Modifier and caps codes have zero ROM entries, so they never emit
    assign emit_next = key_event && key_make && (char_next != 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            skip_reg       <= '0;
            lshift_reg     <= 1'b0;
            rshift_reg     <= 1'b0;
            lctrl_reg      <= 1'b0;
            rctrl_reg      <= 1'b0;
            lalt_reg       <= 1'b0;
            ralt_reg       <= 1'b0;
            caps_reg       <= 1'b0;
            caps_held_reg  <= 1'b0;
            char_reg       <= 8'h00;
            char_valid_reg <= 1'b0;
            reset_req_reg  <= 1'b0;
        end else begin
            char_valid_reg <= emit_next;
            if (emit_next) begin
                char_reg <= char_next;
            end
            reset_req_reg <= scancode_valid && (state_reg == ST_IDLE) &&
                             (scancode == CODE_BAT_OK);

            if (scancode_valid) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (scancode == CODE_BREAK) begin
                            state_reg <= ST_BREAK;
                        end else if (scancode == CODE_EXT) begin
                            state_reg <= ST_EXT;
                        end else if (scancode == CODE_PAUSE) begin
                            state_reg <= ST_PAUSE;
                            skip_reg  <= PAUSE_SKIP;
                        end
                    end
                    ST_EXT: begin
                        state_reg <= (scancode == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                    end
                    ST_PAUSE: begin
                        skip_reg <= skip_reg - 3'd1;
                        if (skip_reg == 3'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end

            // Shift codes ignore the E0 prefix so fake shifts track like real ones
            if (key_event) begin
                case (scancode)
                    KEY_LSHIFT: lshift_reg <= key_make;
                    KEY_RSHIFT: rshift_reg <= key_make;
                    KEY_CTRL: begin
                        if (key_ext) rctrl_reg <= key_make;
                        else         lctrl_reg <= key_make;
                    end
                    KEY_ALT: begin
                        if (key_ext) ralt_reg <= key_make;
                        else         lalt_reg <= key_make;
                    end
                    KEY_CAPS: begin
                        if (!key_ext) begin
                            if (key_make) begin
                                if (!caps_held_reg) begin
                                    caps_reg <= ~caps_reg;
                                end
                                caps_held_reg <= 1'b1;
                            end else begin
                                caps_held_reg <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    ps2_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (char_valid_reg),
        .push_data (char_reg),
        .pop       (ascii_ready),
        .data      (ascii),
        .valid     (ascii_valid),
        .overflow  (overflow)
    );

    assign reset_required = reset_req_reg;
    assign shift          = shift_held;
    assign ctrl           = ctrl_held;
    assign alt            = lalt_reg | ralt_reg;
    assign caps_lock      = caps_reg;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Self-checking bench: directed scenarios plus randomized key events, compared against a
// keyboard-level reference model and a scoreboard of expected characters.
module tb_ps2_keycode_decoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scancode = 8'h00;
    logic       scancode_valid = 1'b0;
    logic       ascii_ready = 1'b0;
    logic [7:0] ascii;
    logic       ascii_valid, reset_required, shift, ctrl, alt, caps_lock, overflow;

    ps2_keycode_decoder #(
        .FIFO_DEPTH   (DEPTH),
        .CTRL_CODES   (1'b1),
        .MAP_EXTENDED (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .ascii          (ascii),
        .ascii_valid    (ascii_valid),
        .ascii_ready    (ascii_ready),
        .reset_required (reset_required),
        .shift          (shift),
        .ctrl           (ctrl),
        .alt            (alt),
        .caps_lock      (caps_lock),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int pop_cnt = 0;
    bit rnd_mode = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keyboard knowledge: letters a..z in alphabetical order, symbol keys with both planes
    logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sym_code [26] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B,
        8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    logic [7:0] sym_lo [26] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D,
        8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
    logic [7:0] sym_hi [26] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
        8'h2A, 8'h28, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D,
        8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
    // Navigation keys after E0 map to 0x80 + position in this list
    logic [7:0] nav_code [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h6C, 8'h69, 8'h7D, 8'h7A,
        8'h70, 8'h71, 8'h4A, 8'h5A};
    logic [7:0] mod_code [5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};

    // Reference model state
    bit m_brk, m_ext, m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral, m_caps, m_caps_held, m_ovf, m_rr;
    int m_pause;
    logic [7:0] exp_q [$];

    task automatic model_reset();
        {m_brk, m_ext, m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral} = '0;
        {m_caps, m_caps_held, m_ovf, m_rr} = '0;
        m_pause = 0;
        exp_q.delete();
    endtask

    task automatic key_event(input logic [7:0] code, input bit ext, input bit make,
                             output bit emit, output logic [7:0] ch);
        emit = 1'b0;
        ch = 8'h00;
        if (code == 8'h12) begin m_lsh = make; return; end
        if (code == 8'h59) begin m_rsh = make; return; end
        if (code == 8'h14) begin if (ext) m_rct = make; else m_lct = make; return; end
        if (code == 8'h11) begin if (ext) m_ral = make; else m_lal = make; return; end
        if (code == 8'h58 && !ext) begin
            if (make) begin
                if (!m_caps_held) m_caps = !m_caps;
                m_caps_held = 1'b1;
            end else begin
                m_caps_held = 1'b0;
            end
            return;
        end
        if (!make) return;
        if (ext) begin
            for (int i = 0; i < 12; i++)
                if (nav_code[i] == code) begin emit = 1'b1; ch = 8'h80 + 8'(i); end
            return;
        end
        for (int i = 0; i < 26; i++) begin
            if (letter_code[i] == code) begin
                emit = 1'b1;
                if (m_lct || m_rct) ch = (8'h41 + 8'(i)) & 8'h1F;
                else if ((m_lsh || m_rsh) != m_caps) ch = 8'h41 + 8'(i);
                else ch = 8'h61 + 8'(i);
            end
            if (sym_code[i] == code) begin
                emit = 1'b1;
                ch = (m_lsh || m_rsh) ? sym_hi[i] : sym_lo[i];
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit emit;
        logic [7:0] ch;
        m_rr = 1'b0;
        if (m_pause > 0) begin m_pause--; return; end
        if (!m_brk && b == 8'hF0) begin m_brk = 1'b1; return; end
        if (!m_brk && !m_ext) begin
            if (b == 8'hE0) begin m_ext = 1'b1; return; end
            if (b == 8'hE1) begin m_pause = 7; return; end
            if (b == 8'hAA) begin m_rr = 1'b1; return; end
        end
        key_event(b, m_ext, !m_brk, emit, ch);
        m_brk = 1'b0;
        m_ext = 1'b0;
        if (emit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ch);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_mode) ascii_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (rnd_mode) begin
            for (int i = 0; i < 50 && exp_q.size() >= DEPTH; i++) begin
                ascii_ready = 1'b1;
                tick();
            end
            ascii_ready = ($urandom_range(0, 3) != 0);
        end
        scancode = b;
        scancode_valid = 1'b1;
        tick();
        scancode_valid = 1'b0;
        model_byte(b);
        check("shift", shift, int'(m_lsh || m_rsh));
        check("ctrl", ctrl, int'(m_lct || m_rct));
        check("alt", alt, int'(m_lal || m_ral));
        check("caps_lock", caps_lock, int'(m_caps));
        check("reset_required", reset_required, int'(m_rr));
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic pop_one();
        ascii_ready = 1'b1;
        tick();
        ascii_ready = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] val);
        int n = 0;
        while (!ascii_valid && n < 10) begin tick(); n++; end
        check({tag, "_valid"}, ascii_valid, 1);
        check(tag, ascii, val);
        pop_one();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        scancode = 8'hF0;
        scancode_valid = 1'b1;
        tick();
        tick();
        scancode_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        check("rst_ascii_valid", ascii_valid, 0);
        check("rst_ascii", ascii, 0);
        check("rst_shift", shift, 0);
        check("rst_ctrl", ctrl, 0);
        check("rst_alt", alt, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_overflow", overflow, 0);
        check("rst_reset_required", reset_required, 0);
    endtask

    // Scoreboard: every accepted handshake must match the next expected character
    always @(negedge clk) begin
        if (!reset && ascii_valid && ascii_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_char", ascii_valid, 0);
            end else begin
                $display("[TB] char %02h", ascii);
                check("char", ascii, exp_q.pop_front());
            end
        end
    end

    initial begin
        int p0;
        model_reset();
        tick();
        do_reset();

        // Single make and latency
        send_byte(8'h1C);
        check("lat_n1_valid", ascii_valid, 0);
        tick();
        check("lat_n2_valid", ascii_valid, 1);
        check("lat_char", ascii, 8'h61);
        pop_one();
        send_seq('{8'hF0, 8'h1C});
        idle(3);
        check("break_no_emit", ascii_valid, 0);

        // Shifted letter then plain letter
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C});
        expect_head("shift_A", 8'h41);
        expect_head("plain_a", 8'h61);
        send_seq('{8'hF0, 8'h1C});

        // Caps lock typematic toggles once; shift inverts caps
        send_seq('{8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C});
        check("caps_single_toggle", caps_lock, 1);
        expect_head("caps_A", 8'h41);
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12});
        expect_head("caps_shift_a", 8'h61);
        send_seq('{8'h58, 8'hF0, 8'h58});
        check("caps_off", caps_lock, 0);

        // Ctrl codes and right ctrl hold
        send_seq('{8'h14, 8'h21});
        expect_head("ctrl_c", 8'h03);
        send_seq('{8'hF0, 8'h21, 8'hF0, 8'h14, 8'hE0, 8'h14, 8'hF0, 8'h14});
        check("rctrl_hold", ctrl, 1);
        send_seq('{8'hE0, 8'hF0, 8'h14});
        check("rctrl_release", ctrl, 0);

        // Pause sequence swallowed, then a normal key
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        idle(3);
        check("pause_no_emit", ascii_valid, 0);
        send_byte(8'h1C);
        expect_head("after_pause_a", 8'h61);
        idle(2);
        check("after_pause_empty", ascii_valid, 0);

        // Extended navigation key and BAT pulse
        send_seq('{8'hE0, 8'h75});
        expect_head("ext_up", 8'h80);
        send_seq('{8'hE0, 8'hF0, 8'h75});
        send_byte(8'hAA);
        check("bat_pulse", reset_required, 1);
        tick();
        check("bat_pulse_end", reset_required, 0);

        // Overflow: nine makes with the consumer stalled
        for (int i = 0; i < 9; i++) send_byte(letter_code[i]);
        idle(3);
        check("ovf_set", overflow, 1);
        check("ovf_model", overflow, int'(m_ovf));
        p0 = pop_cnt;
        ascii_ready = 1'b1;
        for (int i = 0; i < 40 && ascii_valid; i++) tick();
        ascii_ready = 1'b0;
        check("ovf_drain_pops", pop_cnt - p0, 8);
        check("ovf_drain_empty", ascii_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset mid-sequence drops the prefix and clears caps
        send_seq('{8'h58, 8'hF0, 8'h58, 8'hF0});
        do_reset();
        send_byte(8'h1C);
        expect_head("post_reset_a", 8'h61);
        send_seq('{8'hF0, 8'h1C});

        // Randomized key events
        rnd_mode = 1'b1;
        for (int ev = 0; ev < 500; ev++) begin
            int r = $urandom_range(0, 99);
            int k = $urandom_range(0, 9);
            logic [7:0] key;
            logic [7:0] nav;
            if (k < 6) key = letter_code[$urandom_range(0, 25)];
            else if (k < 8) key = sym_code[$urandom_range(0, 25)];
            else key = mod_code[$urandom_range(0, 4)];
            nav = ($urandom_range(0, 3) == 0) ? mod_code[$urandom_range(2, 3)]
                                              : nav_code[$urandom_range(0, 11)];
            if (r < 40) send_byte(key);
            else if (r < 62) send_seq('{8'hF0, key});
            else if (r < 72) send_seq('{8'hE0, nav});
            else if (r < 80) send_seq('{8'hE0, 8'hF0, nav});
            else if (r < 82) send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
            else if (r < 85) send_byte(8'hAA);
            else send_byte(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end
        rnd_mode = 1'b0;
        ascii_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || ascii_valid); i++) tick();
        idle(3);
        check("final_empty", ascii_valid, 0);
        check("final_overflow", overflow, int'(m_ovf));
        check("scoreboard_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
